// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// The issue stage (S1) holds the granted operands and drives the ALU directly.
// The response stage (S2) registers the ALU result together with the owning
// requester id. It is released by a ready/valid handshake with the consumer.
module alu_arbiter #(
   parameter int WIDTH = 4,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [OPW-1:0]   op0,
   input  logic [OPW-1:0]   op1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_ctrl,
   input  logic [WIDTH-1:0] alu_x,
   input  logic             alu_co,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_x,
   output logic             rsp_co,
   input  logic             rsp_ready
);

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   // Issue stage (S1)
   logic             r_s1_valid;
   req_id_e          r_s1_id;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [OPW-1:0]   r_s1_op;

   // Response stage (S2)
   logic             r_rsp_valid;
   req_id_e          r_rsp_id;
   logic [WIDTH-1:0] r_rsp_x;
   logic             r_rsp_co;

   // Round-robin pointer: the requester that wins when both request
   req_id_e          r_ptr;

   logic             w_s2_free;
   logic             w_s1_adv;
   logic             w_s1_open;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_xfer0;
   logic             w_xfer1;

   // S2 can take new data when empty or being drained this cycle.
   // S1 can take a request when empty or moving into S2 this cycle.
   assign w_s2_free = !r_rsp_valid || rsp_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_free;
   assign w_s1_open = !r_s1_valid || w_s1_adv;

   // Grant selection: single requester wins outright, the pointer breaks ties.
   // Grants are also forced low while reset is asserted.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n && w_s1_open) begin
         if (req0 && req1) begin
            if (r_ptr == REQ0) w_gnt0 = 1'b1;
            else               w_gnt1 = 1'b1;
         end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
         end
      end
   end

   assign w_xfer0 = req0 && w_gnt0;
   assign w_xfer1 = req1 && w_gnt1;

   // Issue stage: load the winning request; otherwise empty out on advance
   // while keeping the operands so the ALU inputs stay quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_id    <= REQ0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
      end else if (w_xfer0) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of block order.
         r_s1_valid <= 1'b1;
         r_s1_id    <= REQ0;
         r_s1_a     <= a0;
         r_s1_b     <= b0;
         r_s1_op    <= op0;
      end else if (w_xfer1) begin
         r_s1_valid <= 1'b1;
         r_s1_id    <= REQ1;
         r_s1_a     <= a1;
         r_s1_b     <= b1;
         r_s1_op    <= op1;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Response stage: capture the ALU result on advance, clear on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= REQ0;
         r_rsp_x     <= '0;
         r_rsp_co    <= 1'b0;
      end else if (w_s1_adv) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= r_s1_id;
         r_rsp_x     <= alu_x;
         r_rsp_co    <= alu_co;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Pointer moves to the loser after every transfer and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= REQ0;
      end else if (w_xfer0) begin
         r_ptr <= REQ1;
      end else if (w_xfer1) begin
         r_ptr <= REQ0;
      end
   end

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign alu_a     = r_s1_a;
   assign alu_b     = r_s1_b;
   assign alu_ctrl  = r_s1_op;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_x     = r_rsp_x;
   assign rsp_co    = r_rsp_co;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. It drives directed scenarios and then
// randomized traffic. Expected responses are queued at grant time from a
// high-level ALU/arbitration model. They are popped and compared whenever the
// consumer handshakes a response.
module tb_alu_arbiter;
   localparam int W  = 4;
   localparam int OW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [OW-1:0] op0 = '0, op1 = '0;
   logic          gnt0, gnt1;
   logic [W-1:0]  alu_a, alu_b, alu_x;
   logic [OW-1:0] alu_ctrl;
   logic          alu_co;
   logic          rsp_valid, rsp_id, rsp_co;
   logic [W-1:0]  rsp_x;
   logic          rsp_ready = 1'b0;

   typedef struct {
      logic         id;
      logic [W-1:0] x;
      logic         co;
   } rsp_t;

   rsp_t sb[$];
   int   gnt_log[$];
   int   rsp_log[$];
   logic exp_ptr = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   d0 = 1'b1, d1 = 1'b1;

   always #5 clk = ~clk;

   // Shared ALU stub: {carry, result} for each control code.
   function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [OW-1:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   always_comb {alu_co, alu_x} = alu_f(alu_a, alu_b, alu_ctrl);

   alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .op0(op0), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_x(alu_x), .alu_co(alu_co),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_co(rsp_co),
      .rsp_ready(rsp_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant tracker. Two operations may be in flight; a third fits only when
   // the oldest one leaves this cycle. Ties go to the pointer's requester.
   always @(negedge clk) begin : tracker
      logic accept, e0, e1;
      logic [W:0] r;
      if (rst_n) begin
         accept = (sb.size() < 2) || rsp_ready;
         e0 = 1'b0;
         e1 = 1'b0;
         if (accept) begin
            if (req0 && req1) begin
               e0 = (exp_ptr == 1'b0);
               e1 = (exp_ptr == 1'b1);
            end else begin
               e0 = req0;
               e1 = req1;
            end
         end
         check("gnt0", {31'd0, gnt0}, {31'd0, e0});
         check("gnt1", {31'd0, gnt1}, {31'd0, e1});
         if (req0 && gnt0) begin
            r = alu_f(a0, b0, op0);
            sb.push_back('{id: 1'b0, x: r[W-1:0], co: r[W]});
            gnt_log.push_back(0);
            exp_ptr = 1'b1;
         end else if (req1 && gnt1) begin
            r = alu_f(a1, b1, op1);
            sb.push_back('{id: 1'b1, x: r[W-1:0], co: r[W]});
            gnt_log.push_back(1);
            exp_ptr = 1'b0;
         end
      end
   end

   // Response monitor: every presented response must belong to an issued
   // request, and every accepted one must match the oldest outstanding entry.
   always @(negedge clk) begin : monitor
      rsp_t e;
      if (rst_n && rsp_valid) begin
         check("rsp_owned", {31'd0, (sb.size() != 0)}, 32'd1);
         if (rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
            check("rsp_x",  {28'd0, rsp_x},  {28'd0, e.x});
            check("rsp_co", {31'd0, rsp_co}, {31'd0, e.co});
            rsp_log.push_back(int'(rsp_id));
         end
      end
   end

   // Randomized driver: operands change only once the previous request has
   // been granted, so they stay stable while a request waits.
   task automatic drive(input int n, input int p_req, input int p_rdy);
      for (int i = 0; i < n; i++) begin
         if (!req0 || d0) begin
            req0 = ($urandom_range(99) < p_req);
            a0 = W'($urandom); b0 = W'($urandom); op0 = OW'($urandom);
         end
         if (!req1 || d1) begin
            req1 = ($urandom_range(99) < p_req);
            a1 = W'($urandom); b1 = W'($urandom); op1 = OW'($urandom);
         end
         rsp_ready = ($urandom_range(99) < p_rdy);
         @(negedge clk);
         d0 = req0 && gnt0;
         d1 = req1 && gnt1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      req0 = 1'b0;
      req1 = 1'b0;
      rsp_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int gb, rb;
      logic [W-1:0] sx;
      logic sid, sco;

      // Reset state with both requesters asking.
      rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
      a0 = 4'd5; b0 = 4'd3; a1 = 4'd7; b1 = 4'd2;
      #12;
      check("rst_gnt0", {31'd0, gnt0}, 32'd0);
      check("rst_gnt1", {31'd0, gnt1}, 32'd0);
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_id", {31'd0, rsp_id}, 32'd0);
      check("rst_x", {28'd0, rsp_x}, 32'd0);
      check("rst_co", {31'd0, rsp_co}, 32'd0);
      check("rst_alu_a", {28'd0, alu_a}, 32'd0);
      check("rst_alu_b", {28'd0, alu_b}, 32'd0);
      check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Single requester 0: grant, ALU drive, and response on the next cycles.
      req0 = 1'b1; a0 = 4'b1001; b0 = 4'b0000; op0 = 3'd0;
      @(negedge clk);
      check("s33_gnt0", {31'd0, gnt0}, 32'd1);
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      check("s33_alu_a", {28'd0, alu_a}, 32'd9);
      @(posedge clk); @(negedge clk);
      check("s33_valid", {31'd0, rsp_valid}, 32'd1);
      check("s33_id", {31'd0, rsp_id}, 32'd0);
      check("s33_x", {28'd0, rsp_x}, 32'd9);
      check("s33_co", {31'd0, rsp_co}, 32'd0);
      @(posedge clk); #1;

      // Requester 1 add with carry-out; also moves the pointer back to 0.
      req1 = 1'b1; a1 = 4'b1111; b1 = 4'b0001; op1 = 3'd0;
      @(negedge clk);
      check("s35_gnt1", {31'd0, gnt1}, 32'd1);
      @(posedge clk); #1;
      req1 = 1'b0;
      @(negedge clk); @(posedge clk); @(negedge clk);
      check("s35_valid", {31'd0, rsp_valid}, 32'd1);
      check("s35_id", {31'd0, rsp_id}, 32'd1);
      check("s35_x", {28'd0, rsp_x}, 32'd0);
      check("s35_co", {31'd0, rsp_co}, 32'd1);
      @(posedge clk); #1;
      idle(2);

      // Both requesting with no backpressure: alternating grants, one per cycle.
      d0 = 1'b1; d1 = 1'b1;
      gb = gnt_log.size(); rb = rsp_log.size();
      drive(4, 100, 100);
      idle(4);
      check("s34_ngnt", gnt_log.size() - gb, 32'd4);
      check("s34_nrsp", rsp_log.size() - rb, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (gb + i < gnt_log.size()) check("s34_gnt_order", gnt_log[gb + i], i % 2);
         if (rb + i < rsp_log.size()) check("s34_rsp_order", rsp_log[rb + i], i % 2);
      end

      // Backpressure for 5 cycles: two transfers, then a frozen response.
      d0 = 1'b1; d1 = 1'b1;
      gb = gnt_log.size(); rb = rsp_log.size();
      drive(3, 100, 0);
      sx = rsp_x; sid = rsp_id; sco = rsp_co;
      drive(2, 100, 0);
      check("s36_ngnt", gnt_log.size() - gb, 32'd2);
      check("s36_valid", {31'd0, rsp_valid}, 32'd1);
      check("s36_hold_x", {28'd0, rsp_x}, {28'd0, sx});
      check("s36_hold_id", {31'd0, rsp_id}, {31'd0, sid});
      check("s36_hold_co", {31'd0, rsp_co}, {31'd0, sco});
      idle(4);
      check("s36_nrsp", rsp_log.size() - rb, 32'd2);
      if (rb + 1 < rsp_log.size()) begin
         check("s36_first", rsp_log[rb], 32'd0);
         check("s36_second", rsp_log[rb + 1], 32'd1);
      end
      check("s36_drained", sb.size(), 32'd0);

      // Reset between edges with both stages full.
      d0 = 1'b1; d1 = 1'b1;
      drive(2, 100, 0);
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("s37_valid", {31'd0, rsp_valid}, 32'd0);
      check("s37_alu_a", {28'd0, alu_a}, 32'd0);
      check("s37_alu_b", {28'd0, alu_b}, 32'd0);
      check("s37_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      check("s37_gnt0", {31'd0, gnt0}, 32'd0);
      check("s37_gnt1", {31'd0, gnt1}, 32'd0);
      sb.delete();
      exp_ptr = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("s37_first_gnt0", {31'd0, gnt0}, 32'd1);
      check("s37_first_gnt1", {31'd0, gnt1}, 32'd0);
      @(posedge clk); #1;
      idle(4);
      check("s37_drained", sb.size(), 32'd0);

      // Randomized traffic with random backpressure.
      d0 = 1'b1; d1 = 1'b1;
      drive(400, 60, 70);
      idle(6);
      check("final_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
